// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state encoding and sizing helpers shared by the PLL reset sequencer.
package pll_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLLRST    = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lock_sync.sv
// lock_sync: multi-flop synchronizer for an asynchronous status input, clears to 0 on reset.
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: pulses PLL reset, waits for stable lock, then releases SoC reset;
// retries on lock timeout, re-sequences on lock loss, parks in FAIL after too many retries.
module pll_reset_seq
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 27000,
    parameter int LOCK_STABLE_CYC  = 2700,
    parameter int MAX_RETRIES      = 3,
    parameter int SYNC_STAGES      = 2
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               lock_i,
    input  logic               restart_i,
    output logic               pll_reset_o,
    output logic               sys_reset_o,
    output logic               locked_o,
    output logic               fail_o,
    output logic [3:0]         retry_cnt_o,
    output logic [7:0]         lost_cnt_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int TW = timer_w(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] ST_LAST  = TW'(LOCK_STABLE_CYC - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    lost_q, lost_d;
    logic          pll_rst_q, sys_rst_q, locked_q, fail_q;
    logic          lock_s;

    lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i(clkin),
        .rst_i(reset),
        .d_i  (lock_i),
        .q_o  (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            PLLRST:    if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (timer_q == TO_LAST) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == RETRY_MAX) ? FAIL : PLLRST;
                end
            end
            // a drop on the last stable cycle must win over promotion to RUN
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == ST_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLLRST;
                    retry_d = '0;
                    lost_d  = lost_q + 8'(lost_q != 8'hFF);
                end
            end
            FAIL: begin
                if (restart_i) begin
                    state_d = PLLRST;
                    retry_d = '0;
                end
            end
            default: state_d = PLLRST;
        endcase
        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q   <= PLLRST;
            timer_q   <= '0;
            retry_q   <= '0;
            lost_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= (state_d == PLLRST) || (state_d == FAIL);
            sys_rst_q <= (state_d != RUN);
            locked_q  <= (state_d == RUN);
            fail_q    <= (state_d == FAIL);
        end
    end

    assign pll_reset_o = pll_rst_q;
    assign sys_reset_o = sys_rst_q;
    assign locked_o    = locked_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;
    assign lost_cnt_o  = lost_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed sequence covering start-up, glitch, timeout, restart, loss and async reset.
module tb_pll_reset_seq;

    logic       clkin = 1'b0;
    logic       reset;
    logic       lock_i;
    logic       restart_i;
    logic       pll_reset_o;
    logic       sys_reset_o;
    logic       locked_o;
    logic       fail_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] lost_cnt_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_PLLRST = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    pll_reset_seq #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(50),
        .LOCK_STABLE_CYC (10),
        .MAX_RETRIES     (3),
        .SYNC_STAGES     (2)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .lock_i     (lock_i),
        .restart_i  (restart_i),
        .pll_reset_o(pll_reset_o),
        .sys_reset_o(sys_reset_o),
        .locked_o   (locked_o),
        .fail_o     (fail_o),
        .retry_cnt_o(retry_cnt_o),
        .lost_cnt_o (lost_cnt_o),
        .state_o    (state_o)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int n = 0;
        while (state_o !== s && n < max) begin
            step(1);
            n++;
        end
        chk(tag, {29'd0, state_o}, {29'd0, s});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, {29'd0, state_o}, {29'd0, S_PLLRST});
        chk({tag, "_pll"},   {31'd0, pll_reset_o}, 32'd1);
        chk({tag, "_sys"},   {31'd0, sys_reset_o}, 32'd1);
        chk({tag, "_lock"},  {31'd0, locked_o}, 32'd0);
        chk({tag, "_fail"},  {31'd0, fail_o}, 32'd0);
        chk({tag, "_retry"}, {28'd0, retry_cnt_o}, 32'd0);
        chk({tag, "_lost"},  {24'd0, lost_cnt_o}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        lock_i = 1'b0;
        restart_i = 1'b0;
        step(2);
        chk_reset_vals("rst");

        // normal start: 4-cycle PLL reset pulse
        reset = 1'b0;
        step(3);
        chk("pulse_hi3", {31'd0, pll_reset_o}, 32'd1);
        step(1);
        chk("pulse_lo4", {31'd0, pll_reset_o}, 32'd0);
        chk("wait_entry", {29'd0, state_o}, {29'd0, S_WAIT});
        step(20);
        lock_i = 1'b1;
        step(2);
        chk("sync_wait", {29'd0, state_o}, {29'd0, S_WAIT});
        step(1);
        chk("stable_e2", {29'd0, state_o}, {29'd0, S_STABLE});
        step(9);
        chk("sys_hi_e11", {31'd0, sys_reset_o}, 32'd1);
        step(1);
        chk("sys_lo_e12", {31'd0, sys_reset_o}, 32'd0);
        chk("locked", {31'd0, locked_o}, 32'd1);
        chk("run_retry", {28'd0, retry_cnt_o}, 32'd0);
        chk("run_state", {29'd0, state_o}, {29'd0, S_RUN});

        // restart outside FAIL is ignored
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        step(1);
        chk("restart_run", {29'd0, state_o}, {29'd0, S_RUN});

        // loss in RUN
        lock_i = 1'b0;
        step(2);
        chk("loss_e1_sys", {31'd0, sys_reset_o}, 32'd0);
        step(1);
        chk("loss_e2_sys", {31'd0, sys_reset_o}, 32'd1);
        chk("loss_e2_pll", {31'd0, pll_reset_o}, 32'd1);
        chk("loss_e2_cnt", {24'd0, lost_cnt_o}, 32'd1);
        chk("loss_e2_lock", {31'd0, locked_o}, 32'd0);
        step(3);
        chk("reseq_pll_hi", {31'd0, pll_reset_o}, 32'd1);
        step(1);
        chk("reseq_wait", {29'd0, state_o}, {29'd0, S_WAIT});

        // glitch at STABLE count 6
        lock_i = 1'b1;
        step(9);
        chk("glitch_pre", {29'd0, state_o}, {29'd0, S_STABLE});
        lock_i = 1'b0;
        step(3);
        chk("glitch_wait", {29'd0, state_o}, {29'd0, S_WAIT});
        chk("glitch_sys", {31'd0, sys_reset_o}, 32'd1);
        lock_i = 1'b1;
        step(12);
        chk("glitch_e11", {31'd0, sys_reset_o}, 32'd1);
        step(1);
        chk("glitch_e12", {31'd0, sys_reset_o}, 32'd0);
        chk("glitch_run", {29'd0, state_o}, {29'd0, S_RUN});

        // loss, then drop exactly on the last STABLE cycle
        lock_i = 1'b0;
        wait_state(S_PLLRST, 10, "loss2");
        chk("loss2_cnt", {24'd0, lost_cnt_o}, 32'd2);
        wait_state(S_WAIT, 10, "loss2_wait");
        lock_i = 1'b1;
        step(10);
        lock_i = 1'b0;
        step(2);
        chk("last_stable", {29'd0, state_o}, {29'd0, S_STABLE});
        step(1);
        chk("drop_wins", {29'd0, state_o}, {29'd0, S_WAIT});
        chk("drop_sys", {31'd0, sys_reset_o}, 32'd1);

        // timeouts: three retries then FAIL
        step(49);
        chk("to1_wait", {29'd0, state_o}, {29'd0, S_WAIT});
        step(1);
        chk("to1_rst", {29'd0, state_o}, {29'd0, S_PLLRST});
        chk("to1_retry", {28'd0, retry_cnt_o}, 32'd1);
        step(3);
        chk("to1_pll_hi", {31'd0, pll_reset_o}, 32'd1);
        step(1);
        chk("to1_pll_lo", {31'd0, pll_reset_o}, 32'd0);
        step(50);
        chk("to2_rst", {29'd0, state_o}, {29'd0, S_PLLRST});
        chk("to2_retry", {28'd0, retry_cnt_o}, 32'd2);
        step(4);
        chk("to2_wait", {29'd0, state_o}, {29'd0, S_WAIT});
        step(49);
        chk("to3_wait", {29'd0, state_o}, {29'd0, S_WAIT});
        step(1);
        chk("fail_state", {29'd0, state_o}, {29'd0, S_FAIL});
        chk("fail_o", {31'd0, fail_o}, 32'd1);
        chk("fail_retry", {28'd0, retry_cnt_o}, 32'd3);
        step(10);
        chk("fail_pll", {31'd0, pll_reset_o}, 32'd1);
        chk("fail_sys", {31'd0, sys_reset_o}, 32'd1);
        chk("fail_hold", {29'd0, state_o}, {29'd0, S_FAIL});

        // restart from FAIL
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        chk("restart_state", {29'd0, state_o}, {29'd0, S_PLLRST});
        chk("restart_fail", {31'd0, fail_o}, 32'd0);
        chk("restart_retry", {28'd0, retry_cnt_o}, 32'd0);
        lock_i = 1'b1;
        wait_state(S_RUN, 40, "restart_run");

        // lost count saturation
        for (int i = 0; i < 300; i++) begin
            lock_i = 1'b0;
            wait_state(S_PLLRST, 10, "sat_drop");
            lock_i = 1'b1;
            wait_state(S_RUN, 40, "sat_run");
        end
        chk("lost_sat", {24'd0, lost_cnt_o}, 32'd255);

        // async reset between edges mid-WAIT_LOCK
        lock_i = 1'b0;
        wait_state(S_WAIT, 20, "ar_wait");
        step(5);
        #1 reset = 1'b1;
        #1;
        chk_reset_vals("async");
        step(1);
        reset = 1'b0;
        step(3);
        chk("ar_pll_hi", {31'd0, pll_reset_o}, 32'd1);
        step(1);
        chk("ar_pll_lo", {31'd0, pll_reset_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
